// File: rtl/nor_sweep_checker.sv
// nor_sweep_checker
//   Exhaustive stimulus/check engine for an external N-input NOR gate.
//   It steps vec through all 2^N input combinations and holds each one
//   for HOLD cycles. On the last cycle of each hold window it compares
//   dut_out with the ideal NOR of vec. It counts mismatches in a
//   saturating counter and records the first failing vector.
//
//   Optional build macro: SWEEP_GRAY_EN
//     defined   -> vectors are visited in reflected Gray order (i ^ (i>>1)),
//                  so consecutive vectors differ in exactly one input bit.
//     undefined -> vectors are visited in plain binary order (i).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   level request to begin a sweep (sampled in IDLE only)
//   abort      in   synchronous cancel of a running sweep
//   dut_out    in   output of the NOR under test
//   vec [N]    out  registered vector driven to the DUT inputs
//   busy       out  sweep in progress
//   done       out  sweep complete, results stable
//   err_cnt    out  saturating count of mismatching vectors
//   fail_seen  out  at least one mismatch this sweep
//   first_fail out  vector of the first mismatch (valid when fail_seen)
module nor_sweep_checker #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 5,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          dut_out,
  output logic [N-1:0]  vec,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_cnt,
  output logic          fail_seen,
  output logic [N-1:0]  first_fail
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam int unsigned    HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N:0]     IDX_LAST  = {1'b0, {N{1'b1}}};

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic [N:0]    idx;
  logic [N-1:0]  idx_inc;
  logic          window_end;
  logic          last_vec;
  logic          exp_out;
  logic          mismatch;

  function automatic logic [N-1:0] order(input logic [N-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign idx_inc    = idx[N-1:0] + N'(1);
  assign window_end = (hold_cnt == HOLD_LAST);
  assign last_vec   = (idx == IDX_LAST);
  assign exp_out    = ~|vec;
  // Case inequality so an X/Z on dut_out counts as a mismatch in simulation.
  assign mismatch   = (dut_out !== exp_out);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = APPLY;
      APPLY: begin
        if (abort)                      state_nx = IDLE;
        else if (window_end && last_vec) state_nx = DONE;
      end
      DONE:  if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == APPLY);
    done = (state == DONE);
  end

  // Sweep datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      hold_cnt   <= '0;
      idx        <= '0;
      err_cnt    <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            vec        <= order('0);
            hold_cnt   <= '0;
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
          end
        end
        APPLY: begin
          // Abort wins over a compare on the same edge; results keep
          // whatever was accumulated so far.
          if (abort) begin
            vec      <= '0;
            hold_cnt <= '0;
            idx      <= '0;
          end else if (window_end) begin
            if (mismatch) begin
              if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
              if (!fail_seen) begin
                fail_seen  <= 1'b1;
                first_fail <= vec;
              end
            end
            if (!last_vec) begin
              idx      <= idx + (N+1)'(1);
              vec      <= order(idx_inc);
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_sweep_checker.sv
module tb_nor_sweep_checker;

  localparam int unsigned N    = 3;
  localparam int unsigned HOLD = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   mode = 2'd0;   // 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1

  logic         dut_out_a, dut_out_b;
  logic [N-1:0] vec_a, vec_b, ff_a, ff_b;
  logic         busy_a, busy_b, done_a, done_b, fs_a, fs_b;
  logic [7:0]   err_a;
  logic [1:0]   err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    dut_out_a = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : ~|vec_a;
    dut_out_b = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : ~|vec_b;
  end

  nor_sweep_checker #(.N(N), .HOLD(HOLD), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_out(dut_out_a), .vec(vec_a), .busy(busy_a), .done(done_a),
    .err_cnt(err_a), .fail_seen(fs_a), .first_fail(ff_a)
  );

  nor_sweep_checker #(.N(N), .HOLD(HOLD), .CW(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_out(dut_out_b), .vec(vec_b), .busy(busy_b), .done(done_b),
    .err_cnt(err_b), .fail_seen(fs_b), .first_fail(ff_b)
  );

  function automatic logic [N-1:0] ord(input int unsigned i);
    logic [N-1:0] b;
    b = i[N-1:0];
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [N-1:0] prev;
    prev = '0;

    // Reset state
    #12;
    check("rst_vec", 32'(vec_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_fs", 32'(fs_a), 0);
    check("rst_ff", 32'(ff_a), 0);
    rst_n = 1'b1;
    tick_n(2);
    check("idle_busy", 32'(busy_a), 0);

    // 1. Ideal DUT, full sweep with order and timing checks
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned i = 0; i < (1 << N); i++) begin
      for (int unsigned h = 0; h < HOLD; h++) begin
        check("t1_vec", 32'(vec_a), 32'(ord(i)));
        check("t1_busy", 32'(busy_a), 1);
`ifdef SWEEP_GRAY_EN
        if (i > 0 && h == 0) check("t1_onebit", $countones(vec_a ^ prev), 1);
`endif
        prev = vec_a;
        tick();
      end
    end
    check("t1_done", 32'(done_a), 1);
    check("t1_busy_end", 32'(busy_a), 0);
    check("t1_vec_last", 32'(vec_a), 32'(ord((1 << N) - 1)));
    check("t1_err", 32'(err_a), 0);
    check("t1_fs", 32'(fs_a), 0);
    tick();
    check("t1_done_fall", 32'(done_a), 0);
    tick();
    check("t1_idle_stays", 32'(busy_a), 0);

    // 2. Stuck-at-0; start held high through the sweep and in DONE
    mode = 2'd1;
    start = 1'b1;
    tick_n(1 + (1 << N) * HOLD);
    check("t2_done", 32'(done_a), 1);
    check("t2_err", 32'(err_a), 1);
    check("t2_fs", 32'(fs_a), 1);
    check("t2_ff", 32'(ff_a), 0);
    abort = 1'b1;
    tick_n(3);
    abort = 1'b0;
    check("t2_done_hold", 32'(done_a), 1);
    check("t2_no_restart", 32'(busy_a), 0);
    check("t2_err_hold", 32'(err_a), 1);
    start = 1'b0;
    tick();
    check("t2_done_fall", 32'(done_a), 0);

    // 3. Stuck-at-1: 7 mismatches, CW=2 saturates at 3
    mode = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_err_clr", 32'(err_a), 0);
    check("t3_fs_clr", 32'(fs_a), 0);
    tick_n((1 << N) * HOLD);
    check("t3_done", 32'(done_a), 1);
    check("t3_err8", 32'(err_a), 7);
    check("t3_err2_sat", 32'(err_b), 3);
    check("t3_ff", 32'(ff_a), 32'(ord(1)));
    check("t3_ff_sat", 32'(ff_b), 32'(ord(1)));
    check("t3_fs", 32'(fs_b), 1);
    tick();

    // 4. Asynchronous reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(16);
    check("t4_err_before", 32'(err_a), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_vec", 32'(vec_a), 0);
    check("t4_busy", 32'(busy_a), 0);
    check("t4_err", 32'(err_a), 0);
    check("t4_fs", 32'(fs_a), 0);
    check("t4_ff", 32'(ff_a), 0);
    #3;
    rst_n = 1'b1;
    mode = 2'd0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_restart_vec", 32'(vec_a), 0);
    check("t4_restart_busy", 32'(busy_a), 1);
    tick_n((1 << N) * HOLD);
    check("t4_done", 32'(done_a), 1);
    check("t4_err_end", 32'(err_a), 0);
    tick();

    // 5. Abort during vector index 2, then full restart
    mode = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(2 * HOLD + 1);
    check("t5_vec_at_abort", 32'(vec_a), 32'(ord(2)));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", 32'(busy_a), 0);
    check("t5_vec", 32'(vec_a), 0);
    check("t5_done", 32'(done_a), 0);
    check("t5_err_partial", 32'(err_a), 1);
    check("t5_ff_partial", 32'(ff_a), 32'(ord(1)));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle_abort", 32'(busy_a), 0);
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_err_clr", 32'(err_a), 0);
    check("t5_fs_clr", 32'(fs_a), 0);
    check("t5_vec0", 32'(vec_a), 0);
    tick_n((1 << N) * HOLD);
    check("t5_done_end", 32'(done_a), 1);
    check("t5_err_end", 32'(err_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
